// File: rtl/sd_dat_tx_lanes.sv
// SD DAT write path: pops tx-buffer words and serialises them onto 1/4/8 DAT lanes
// with per-lane CRC16, start/end bits, block counting and card-busy wait.
module sd_dat_tx_lanes #(
  parameter int unsigned MAX_LANES  = 4,
  parameter int unsigned BLK_SIZE_W = 12,
  parameter int unsigned BLK_CNT_W  = 16,
  parameter int unsigned BUSY_TO    = 65535
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [1:0]            bus_width_sel,
  input  logic [BLK_SIZE_W-1:0] block_size,
  input  logic [BLK_CNT_W-1:0]  block_count,
  input  logic [31:0]           buf_data,
  input  logic                  buf_empty,
  output logic                  buf_rd,
  output logic [MAX_LANES-1:0]  dat_out,
  output logic                  dat_oe,
  input  logic                  dat0_in,
  output logic                  busy,
  output logic [BLK_CNT_W-1:0]  blocks_done,
  output logic                  done,
  output logic [2:0]            err
);

  localparam int unsigned BUSY_W = $clog2(BUSY_TO + 1);
  localparam logic [MAX_LANES-1:0] ONES = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_BUF, S_START, S_DATA, S_CRC, S_END, S_TURN, S_BUSY, S_FIN
  } state_t;

  state_t                state;
  logic [31:0]           shift;
  logic [3:0]            lanes_q;
  logic [4:0]            beat_last_q;
  logic [4:0]            beat;
  logic [BLK_SIZE_W-1:0] blk_words_q;
  logic [BLK_SIZE_W-1:0] words_left;
  logic [BLK_CNT_W-1:0]  blk_cnt_q;
  logic [3:0]            cnt;
  logic [BUSY_W-1:0]     busy_cnt;
  logic [15:0]           crc_r [MAX_LANES];

  logic [3:0]            lanes_in_c;
  logic [4:0]            beat_last_in_c;
  logic                  legal_c;
  logic                  last_beat_c;
  logic                  last_word_c;
  logic [MAX_LANES-1:0]  dbits_c;
  logic [MAX_LANES-1:0]  crc_msb_c;
  logic [MAX_LANES-1:0]  unused_c;
  logic [BLK_CNT_W-1:0]  blk_next_c;
  logic                  crc_clr_c;
  logic                  crc_upd_c;
  logic                  crc_shift_c;

  // Top n bits of a word onto lanes n-1..0 (MSB on the highest used lane); unused lanes = 1.
  function automatic logic [MAX_LANES-1:0] pick(input logic [31:0] w, input logic [3:0] n);
    logic [31:0] top;
    top = w >> (6'd32 - 6'(n));
    return (ONES << n) | top[MAX_LANES-1:0];
  endfunction

  always_comb begin
    lanes_in_c     = 4'd0;
    beat_last_in_c = 5'd0;
    case (bus_width_sel)
      2'd0:    begin lanes_in_c = 4'd1; beat_last_in_c = 5'd31; end
      2'd1:    begin lanes_in_c = 4'd4; beat_last_in_c = 5'd7;  end
      2'd2:    begin lanes_in_c = 4'd8; beat_last_in_c = 5'd3;  end
      default: begin lanes_in_c = 4'd0; beat_last_in_c = 5'd0;  end
    endcase
    legal_c = (bus_width_sel != 2'd3) && (32'(lanes_in_c) <= MAX_LANES) &&
              (block_size[1:0] == 2'b00) && (block_size != '0);
  end

  assign last_beat_c = (beat == beat_last_q);
  assign last_word_c = (words_left == BLK_SIZE_W'(1));
  assign unused_c    = ONES << lanes_q;
  assign blk_next_c  = blocks_done + BLK_CNT_W'(1);
  assign dbits_c     = (state == S_DATA && last_beat_c && !last_word_c) ?
                       pick(buf_data, lanes_q) : pick(shift, lanes_q);

  // Pop on the cycle the head word is consumed: block start or word boundary mid-block.
  assign buf_rd = !RESET && !buf_empty &&
                  ((state == S_WAIT_BUF) || (state == S_DATA && last_beat_c && !last_word_c));

  assign crc_clr_c   = (state == S_WAIT_BUF) && !buf_empty;
  assign crc_upd_c   = (state == S_START) || (state == S_DATA && !(last_beat_c && last_word_c));
  assign crc_shift_c = (state == S_CRC) || (state == S_DATA && last_beat_c && last_word_c);

  // Independent CRC16-CCITT per lane, updated as each data bit is launched, then shifted out.
  for (genvar g = 0; g < int'(MAX_LANES); g++) begin : g_crc
    always_ff @(posedge CLK) begin
      if (RESET || crc_clr_c) begin
        crc_r[g] <= 16'h0000;
      end else if (crc_upd_c) begin
        crc_r[g] <= {crc_r[g][14:0], 1'b0} ^ ((crc_r[g][15] ^ dbits_c[g]) ? 16'h1021 : 16'h0000);
      end else if (crc_shift_c) begin
        crc_r[g] <= {crc_r[g][14:0], 1'b0};
      end
    end
    assign crc_msb_c[g] = crc_r[g][15];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      dat_out     <= ONES;
      dat_oe      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      blocks_done <= '0;
      err         <= 3'b000;
      shift       <= 32'h0;
      lanes_q     <= 4'd1;
      beat_last_q <= 5'd31;
      beat        <= 5'd0;
      blk_words_q <= '0;
      words_left  <= '0;
      blk_cnt_q   <= '0;
      cnt         <= 4'd0;
      busy_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          lanes_q     <= lanes_in_c;
          beat_last_q <= beat_last_in_c;
          blk_words_q <= block_size >> 2;
          blk_cnt_q   <= (block_count == '0) ? BLK_CNT_W'(1) : block_count;
          blocks_done <= '0;
          busy        <= 1'b1;
          if (legal_c) begin
            err   <= 3'b000;
            state <= S_WAIT_BUF;
          end else begin
            err   <= 3'b001;
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_WAIT_BUF: if (!buf_empty) begin
          shift      <= buf_data;
          dat_oe     <= 1'b1;
          dat_out    <= unused_c;
          beat       <= 5'd0;
          words_left <= blk_words_q;
          state      <= S_START;
        end
        S_START: begin
          dat_out <= dbits_c;
          shift   <= shift << lanes_q;
          beat    <= 5'd0;
          state   <= S_DATA;
        end
        S_DATA: begin
          if (!last_beat_c) begin
            dat_out <= dbits_c;
            shift   <= shift << lanes_q;
            beat    <= beat + 5'd1;
          end else if (!last_word_c) begin
            if (buf_empty) begin
              err[1]  <= 1'b1;
              dat_oe  <= 1'b0;
              dat_out <= ONES;
              done    <= 1'b1;
              state   <= S_FIN;
            end else begin
              dat_out    <= dbits_c;
              shift      <= buf_data << lanes_q;
              beat       <= 5'd0;
              words_left <= words_left - BLK_SIZE_W'(1);
            end
          end else begin
            dat_out <= crc_msb_c | unused_c;
            cnt     <= 4'd0;
            state   <= S_CRC;
          end
        end
        S_CRC: begin
          if (cnt == 4'd15) begin
            dat_out <= ONES;
            state   <= S_END;
          end else begin
            dat_out <= crc_msb_c | unused_c;
            cnt     <= cnt + 4'd1;
          end
        end
        S_END: begin
          dat_oe <= 1'b0;
          cnt    <= 4'd0;
          state  <= S_TURN;
        end
        S_TURN: begin
          if (cnt == 4'd1) begin
            busy_cnt <= '0;
            state    <= S_BUSY;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        // Card holds DAT0 low while programming; release ends the block.
        S_BUSY: begin
          if (dat0_in) begin
            blocks_done <= blk_next_c;
            if (blk_next_c == blk_cnt_q) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              state <= S_WAIT_BUF;
            end
          end else if (busy_cnt == BUSY_W'(BUSY_TO - 1)) begin
            err[2] <= 1'b1;
            done   <= 1'b1;
            state  <= S_FIN;
          end else begin
            busy_cnt <= busy_cnt + BUSY_W'(1);
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dat_tx_lanes.sv
// Scoreboard bench for sd_dat_tx_lanes: DAT bursts and done pulses are checked by a
// monitor against expectations queued by the stimulus.
module tb_sd_dat_tx_lanes;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [1:0]  bus_width_sel;
  logic [11:0] block_size;
  logic [15:0] block_count;
  logic [31:0] buf_data;
  logic        buf_empty;
  logic        buf_rd;
  logic [3:0]  dat_out;
  logic        dat_oe;
  logic        dat0_in;
  logic        busy;
  logic [15:0] blocks_done;
  logic        done;
  logic [2:0]  err;

  sd_dat_tx_lanes #(.MAX_LANES(4), .BLK_SIZE_W(12), .BLK_CNT_W(16), .BUSY_TO(100)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .bus_width_sel(bus_width_sel),
    .block_size(block_size), .block_count(block_count), .buf_data(buf_data),
    .buf_empty(buf_empty), .buf_rd(buf_rd), .dat_out(dat_out), .dat_oe(dat_oe),
    .dat0_in(dat0_in), .busy(busy), .blocks_done(blocks_done), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // FWFT tx buffer model
  logic [31:0] mem [256];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;
  assign buf_empty = (rd_ptr == wr_ptr);
  assign buf_data  = mem[rd_ptr];
  always @(posedge CLK) if (buf_rd && !buf_empty) rd_ptr <= rd_ptr + 8'd1;

  logic rst_q = 1'b0;
  always @(posedge CLK) rst_q <= RESET;

  typedef struct {
    int          len;
    int          nd;
    int          l;
    logic [3:0]  start_v;
    logic [63:0] head;
    bit          head_chk;
    bit          crc_chk;
    logic [63:0] crcs;
  } burst_t;

  typedef struct {
    logic [2:0] err;
    int         blocks;
    int         pops;
    int         delay;
  } done_t;

  burst_t bq[$];
  done_t  dq[$];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] crc_lane(input logic [31:0] wa, input logic [31:0] wb,
                                           input int nw, input int l, input int lane);
    logic [15:0] c;
    logic [31:0] w;
    logic        b;
    c = 16'h0;
    for (int i = 0; i < nw; i++) begin
      w = (i % 2 == 0) ? wa : wb;
      for (int j = 0; j < 32 / l; j++) begin
        b = w[31 - j * l - (l - 1) + lane];
        c = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic exp_burst(input int len, input int nd, input int l, input logic [3:0] sv,
                           input logic [63:0] head, input bit hc, input bit cc,
                           input logic [63:0] crcs);
    burst_t b;
    b.len = len; b.nd = nd; b.l = l; b.start_v = sv;
    b.head = head; b.head_chk = hc; b.crc_chk = cc; b.crcs = crcs;
    bq.push_back(b);
  endtask

  task automatic exp_done(input logic [2:0] e, input int blocks, input int pops, input int delay);
    done_t d;
    d.err = e; d.blocks = blocks; d.pops = pops; d.delay = delay;
    dq.push_back(d);
  endtask

  // Monitor: decodes DAT bursts and done pulses, compares against queued expectations.
  burst_t      cur;
  done_t       dcur;
  bit          in_burst = 0;
  bit          stray = 0;
  int          idx, nbits, unused_bad, cyc = 0, last_fall = 0, pops = 0, bad_rd = 0;
  logic [63:0] head_got, crc_got;
  logic [3:0]  used;

  always @(negedge CLK) begin
    cyc++;
    if (rst_q) pops = 0;
    if (buf_rd) begin
      pops++;
      if (buf_empty) bad_rd++;
    end
    if (dat_oe) begin
      if (!in_burst) begin
        in_burst = 1; idx = 0; nbits = 0; head_got = '0; crc_got = '0; unused_bad = 0;
        stray = (bq.size() == 0);
        if (stray) chk("unexpected_burst", 64'(bq.size()), 64'd1);
        else cur = bq.pop_front();
      end
      if (!stray) begin
        used = (cur.l == 1) ? 4'b0001 : 4'b1111;
        if ((dat_out | used) != 4'hF) unused_bad++;
        if (idx == 0) chk("start_bits", 64'(dat_out), 64'(cur.start_v));
        else if (idx <= cur.nd) begin
          if (nbits < 64) begin
            head_got = (cur.l == 1) ? {head_got[62:0], dat_out[0]} : {head_got[59:0], dat_out};
            nbits += cur.l;
          end
        end else if (idx <= cur.nd + 16) begin
          for (int k = 0; k < cur.l; k++) crc_got[16*k +: 16] = {crc_got[16*k +: 15], dat_out[k]};
        end else if (idx == cur.nd + 17) chk("end_bits", 64'(dat_out), 64'hF);
      end
      idx++;
    end else if (in_burst) begin
      in_burst  = 0;
      last_fall = cyc;
      if (!stray) begin
        if (cur.len >= 0) chk("burst_len", 64'(idx), 64'(cur.len));
        if (cur.head_chk) chk("data_head", head_got, cur.head);
        if (cur.crc_chk) chk("lane_crc", crc_got, cur.crcs);
        chk("unused_lanes_high", 64'(unused_bad), 64'd0);
      end
    end
    if (done) begin
      done_cnt++;
      if (dq.size() == 0) chk("unexpected_done", 64'(dq.size()), 64'd1);
      else begin
        dcur = dq.pop_front();
        chk("done_err", 64'(err), 64'(dcur.err));
        chk("blocks_done", 64'(blocks_done), 64'(dcur.blocks));
        chk("pop_count", 64'(pops), 64'(dcur.pops));
        chk("rd_while_empty", 64'(bad_rd), 64'd0);
        if (dcur.delay >= 0) chk("done_delay", 64'(cyc - last_fall), 64'(dcur.delay));
      end
      pops = 0;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic xfer(input logic [1:0] sel, input logic [11:0] bs, input logic [15:0] bc);
    @(negedge CLK);
    bus_width_sel = sel; block_size = bs; block_count = bc; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (done_cnt != n0) return;
    end
    chk({nm, "_timeout"}, 64'(done_cnt), 64'(n0 + 1));
  endtask

  logic [63:0] crc4;
  logic [1:0]  bad_sel [3];
  logic [11:0] bad_bs  [3];
  bit          got_oe;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    RESET = 1'b1; start = 1'b0; bus_width_sel = 2'd0; block_size = 12'd4;
    block_count = 16'd1; dat0_in = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_dat_out", 64'(dat_out), 64'hF);
    chk("rst_dat_oe", 64'(dat_oe), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_buf_rd", 64'(buf_rd), 64'd0);
    chk("rst_blocks_done", 64'(blocks_done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    RESET = 1'b0;

    // 1-bit lane, single 4-byte block
    push(32'hA5A5A5A5);
    exp_burst(50, 32, 1, 4'hE, 64'hA5A5A5A5, 1, 1, 64'(crc_lane(32'hA5A5A5A5, 32'h0, 1, 1, 0)));
    exp_done(3'b000, 1, 1, 3);
    xfer(2'd0, 12'd4, 16'd1);
    wait_done("t1", 500);

    // 1-bit lane, 512 bytes of ones
    for (int i = 0; i < 128; i++) push(32'hFFFFFFFF);
    exp_burst(4114, 4096, 1, 4'hE, 64'hFFFFFFFF_FFFFFFFF, 1, 1, 64'h7FA1);
    exp_done(3'b000, 1, 128, 3);
    xfer(2'd0, 12'd512, 16'd1);
    wait_done("t2", 6000);

    // 4 lanes, 3 blocks of 8 bytes; an illegal start mid-transfer must be ignored
    for (int i = 0; i < 3; i++) begin push(32'h01234567); push(32'h89ABCDEF); end
    for (int k = 0; k < 4; k++) crc4[16*k +: 16] = crc_lane(32'h01234567, 32'h89ABCDEF, 2, 4, k);
    for (int i = 0; i < 3; i++) exp_burst(34, 16, 4, 4'h0, 64'h01234567_89ABCDEF, 1, 1, crc4);
    exp_done(3'b000, 3, 6, 3);
    xfer(2'd1, 12'd8, 16'd3);
    repeat (5) @(negedge CLK);
    xfer(2'd3, 12'd6, 16'd1);
    wait_done("t3", 1000);

    // underrun: only one word for an 8-byte block
    push(32'hDEADBEEF);
    exp_burst(9, 8, 4, 4'h0, 64'hDEADBEEF, 1, 0, 64'h0);
    exp_done(3'b010, 0, 1, 0);
    xfer(2'd1, 12'd8, 16'd1);
    wait_done("t4", 500);

    // busy timeout: DAT0 held low after block 1
    push(32'h0F0F1234);
    exp_burst(50, 32, 1, 4'hE, 64'h0F0F1234, 1, 1, 64'(crc_lane(32'h0F0F1234, 32'h0, 1, 1, 0)));
    exp_done(3'b100, 0, 1, 102);
    dat0_in = 1'b0;
    xfer(2'd0, 12'd4, 16'd2);
    wait_done("t5", 1000);
    dat0_in = 1'b1;

    // illegal configurations: 8-bit on 4 lanes, reserved width, size not a multiple of 4
    bad_sel[0] = 2'd2; bad_bs[0] = 12'd4;
    bad_sel[1] = 2'd3; bad_bs[1] = 12'd4;
    bad_sel[2] = 2'd0; bad_bs[2] = 12'd6;
    for (int i = 0; i < 3; i++) begin
      exp_done(3'b001, 0, 0, -1);
      xfer(bad_sel[i], bad_bs[i], 16'd1);
      wait_done("t5b", 50);
    end

    // reset in the middle of DATA
    push(32'h12345678); push(32'h3C3C0FF0);
    exp_burst(-1, 64, 1, 4'hE, 64'h0, 0, 0, 64'h0);
    xfer(2'd0, 12'd8, 16'd1);
    got_oe = 0;
    for (int i = 0; i < 100 && !got_oe; i++) begin
      @(negedge CLK);
      got_oe = dat_oe;
    end
    chk("t6_oe_seen", 64'(got_oe), 64'd1);
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_dat_oe", 64'(dat_oe), 64'd0);
    chk("t6_dat_out", 64'(dat_out), 64'hF);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_buf_rd", 64'(buf_rd), 64'd0);
    RESET = 1'b0;
    repeat (5) @(negedge CLK);

    // clean transfer afterwards consumes the leftover word; block_count 0 acts as 1
    exp_burst(50, 32, 1, 4'hE, 64'h3C3C0FF0, 1, 1, 64'(crc_lane(32'h3C3C0FF0, 32'h0, 1, 1, 0)));
    exp_done(3'b000, 1, 1, 3);
    xfer(2'd0, 12'd4, 16'd0);
    wait_done("t6b", 500);

    repeat (5) @(negedge CLK);
    chk("burst_queue_drained", 64'(bq.size()), 64'd0);
    chk("done_queue_drained", 64'(dq.size()), 64'd0);
    chk("fifo_drained", 64'(buf_empty), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_dat_tx_lanes.md
Name: sd_dat_tx_lanes

Overview:
Parametrised SD DAT write path. It pops 32-bit words from the tx buffer, the FWFT side of buffer_wrapper. It serialises them onto 1, 4 or 8 DAT lanes, appending per-lane CRC16, start bits and end bits. It then counts blocks and waits out card busy on DAT0 between blocks. It sits between buffer_wrapper (tx side) and the DAT pads, and is driven by Transfer Mode, Block Size and Block Count register fields.

Parameters:
MAX_LANES, 4, physical DAT lanes; legal values 1, 4, 8.
BLK_SIZE_W, 12, width of block_size in bytes; maximum 2048.
BLK_CNT_W, 16, width of block_count.
BUSY_TO, 65535, maximum cycles allowed with DAT0 low after a block before a timeout error.

Ports:
CLK  in  1  card-domain clock; all logic is on rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a transfer; ignored unless IDLE
bus_width_sel  in  2  0 = 1-bit, 1 = 4-bit, 2 = 8-bit, 3 = reserved
block_size  in  BLK_SIZE_W  bytes per block; must be a nonzero multiple of 4
block_count  in  BLK_CNT_W  number of blocks; 0 is treated as 1
buf_data  in  32  tx buffer head word, valid whenever !buf_empty
buf_empty  in  1  tx buffer empty
buf_rd  out  1  pop strobe, one cycle per word
dat_out  out  MAX_LANES  DAT lane drive values
dat_oe  out  1  DAT output enable
dat0_in  in  1  sampled DAT0; low means card busy
busy  out  1  high whenever the FSM is not IDLE
blocks_done  out  BLK_CNT_W  blocks completed in the current transfer
done  out  1  one-cycle pulse at transfer end, with or without error
err  out  3  sticky until next start: [0] width illegal, [1] underrun, [2] busy timeout

Behaviour:
- Reset values (RESET high at a clock edge):
  - FSM goes to IDLE; dat_out is all ones; dat_oe=0, buf_rd=0, busy=0, done=0; blocks_done=0; err=0.
  - Reset mid-transfer abandons the block. No done pulse is produced. The buffer is not popped further.
- Inputs are sampled at start:
  - Latch bus_width_sel, block_size and block_count, and clear err and blocks_done.
  - If width is 3, or lanes exceed MAX_LANES, or block_size[1:0]!=0, or block_size==0: set err[0] and pulse done the next cycle; no dat activity.
- Lane count L is 1, 4 or 8. Data cycles per block = block_size*8/L.
- FSM states: IDLE -> WAIT_BUF -> START -> DATA -> CRC -> END -> TURN -> BUSY -> (WAIT_BUF or FIN) -> IDLE.
- WAIT_BUF: dat_oe=0. Stay until !buf_empty, then in the same cycle pulse buf_rd and load the shift register from buf_data.
- START: one cycle; dat_oe=1 and the used lanes are 0; unused lanes are 1.
- DATA:
  - Each cycle, lane k drives shift[31-(L-1)+k]; i.e. for L=4, dat[3:0]=shift[31:28]. Then shift left by L.
  - After 32/L cycles a word is exhausted. If not on the last word, the next word is popped in that same cycle and loaded without a gap.
  - If buf_empty when a pop is needed mid-block: set err[1], set dat_oe=0, go to FIN.
- CRC: each used lane has an independent CRC16-CCITT (x^16+x^12+x^5+1), initialised to 0 at START and updated on that lane's data bits. It emits 16 cycles MSB first.
- END: one cycle with used lanes = 1.
- TURN: 2 cycles with dat_oe=0, to ignore the CRC-status token, which is handled elsewhere.
- BUSY:
  - Count cycles while dat0_in==0.
  - When dat0_in==1: increment blocks_done. If blocks_done reaches block_count go to FIN, else go to WAIT_BUF.
  - If the count reaches BUSY_TO: set err[2] and go to FIN.
- FIN: pulse done for one cycle, then go to IDLE.
- Unused lanes (index >= L) are held at 1 whenever dat_oe=1.
- Latency: start -> WAIT_BUF on the next edge. First start bit appears one cycle after the first pop.
- buf_rd is never asserted while buf_empty=1. buf_rd is never asserted outside WAIT_BUF/DATA.
- start while busy=1 is ignored. Register inputs changing mid-transfer have no effect.

Test Plan:
1. L=1, block_size=4, block_count=1, buf word 0xA5A5A5A5, dat0 high after TURN. Required: 1 start, 32 data cycles bit pattern 1010 0101..., 16 CRC, 1 end; exactly one buf_rd; done pulses with err=0 and blocks_done=1.
2. L=1, block_size=512, data all 0xFFFFFFFF. Required: CRC on dat[0] is 0x7FA1; 128 pops; 4096 data cycles.
3. MAX_LANES=4, L=4, block_size=8, block_count=3, words 0x01234567/0x89ABCDEF repeated. Required: dat[3:0] sequence 0,1,2,...,F per block; 16 data cycles per block; 6 pops; blocks_done=3; done once.
4. buf_empty raised after the first word of an 8-byte block. Required: err=3'b010, dat_oe drops, done pulses, no further buf_rd.
5. dat0_in held low after block 1, BUSY_TO=100. Required: err[2] set after 100 BUSY cycles and blocks_done=0. Separately, bus_width_sel=2 with MAX_LANES=4 gives err[0] and done with no dat_oe.
6. RESET asserted in the middle of DATA. Required: next cycle shows IDLE state, dat_oe=0, dat_out all ones, no done pulse. A following start runs a clean transfer.
